// File: rtl/conv_encoder.sv
// Rate-1/2, K=7 convolutional encoder (133/171 octal) on AXI-Stream, WIDTH bits per beat.
// Define CONV_ENCODER_TAIL_EN to append a zero-flush tail beat after each frame.
module conv_encoder #(
    parameter int WIDTH = 32
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic [WIDTH-1:0]     s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    output logic [2*WIDTH-1:0]   m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast
);

    localparam logic [0:0] ST_DATA = 1'b0;
    localparam logic [0:0] ST_TAIL = 1'b1;

    logic [0:0]         r_state;
    logic [5:0]         r_st;
    logic [2*WIDTH-1:0] r_outData;
    logic               r_outValid;
    logic               r_outLast;

    logic               w_outFree;
    logic               w_accept;
    logic [WIDTH-1:0]   w_encData;
    logic [WIDTH+5:0]   w_ext;
    logic [2*WIDTH-1:0] w_coded;
    logic [5:0]         w_lastBits;

    assign w_outFree     = ~r_outValid | m_axis_tready;
    assign s_axis_tready = w_outFree & (r_state == ST_DATA);
    assign w_accept      = s_axis_tvalid & s_axis_tready;

    assign m_axis_tdata  = r_outData;
    assign m_axis_tvalid = r_outValid;
    assign m_axis_tlast  = r_outLast;

    // w_ext holds the beat's bits above the six past bits in time order, so tap d[n-k] is w_ext[i+6-k].
    always_comb begin
        w_encData = (r_state == ST_TAIL) ? '0 : s_axis_tdata;
        w_ext = '0;
        w_ext[WIDTH+5:6] = w_encData;
        for (int k = 0; k < 6; k++) begin
            w_ext[5-k] = r_st[k];
        end
        w_coded = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_coded[2*i]   = w_ext[i+6] ^ w_ext[i+4] ^ w_ext[i+3] ^ w_ext[i+1] ^ w_ext[i];
            w_coded[2*i+1] = w_ext[i+6] ^ w_ext[i+5] ^ w_ext[i+4] ^ w_ext[i+3] ^ w_ext[i];
        end
        w_lastBits = '0;
        for (int k = 0; k < 6; k++) begin
            w_lastBits[k] = w_encData[WIDTH-1-k];
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state    <= ST_DATA;
            r_st       <= '0;
            r_outData  <= '0;
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
        end else if (r_state == ST_DATA) begin
            if (w_accept) begin
                r_outData  <= w_coded;
                r_outValid <= 1'b1;
`ifdef CONV_ENCODER_TAIL_EN
                // Keep the pre-clear state so the tail beat can flush it.
                r_outLast  <= 1'b0;
                r_st       <= w_lastBits;
                if (s_axis_tlast) begin
                    r_state <= ST_TAIL;
                end
`else
                r_outLast  <= s_axis_tlast;
                r_st       <= s_axis_tlast ? 6'd0 : w_lastBits;
`endif
            end else if (m_axis_tready) begin
                r_outValid <= 1'b0;
            end
        end
`ifdef CONV_ENCODER_TAIL_EN
        else if (w_outFree) begin
            r_outData  <= w_coded;
            r_outValid <= 1'b1;
            r_outLast  <= 1'b1;
            r_st       <= '0;
            r_state    <= ST_DATA;
        end
`endif
    end

endmodule

// File: doc/conv_encoder.md
# conv_encoder

Rate-1/2, constraint-length-7 convolutional encoder (generators 133/171 octal, IEEE 802.11 OFDM). Sits directly downstream of the scrambler. Consumes WIDTH scrambled bits per AXI-Stream beat and produces 2*WIDTH coded bits per beat. Encoder state clears at every frame boundary. An optional tail beat flushes the trellis to zero.

## Interface
- WIDTH, 32: input bits per beat; must be ≥ 6; output is 2*WIDTH bits.
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  reset; synchronous, active-high.
- s_axis_tdata  in  WIDTH  scrambled bits; bit 0 is earliest in time.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  last beat of frame.
- m_axis_tdata  out  2*WIDTH  coded bits; [2i] = A output and [2i+1] = B output for input bit i.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  last output beat of frame.

## Operation
- Reset is synchronous and active-high; all logic is clocked on the rising edge of aclk.
- State register st[5:0]: st[k] = input bit d[n-1-k], so st[0] is the most recent past bit.
- For each bit i of the beat, with d[n] = s_axis_tdata[i] and earlier bits taken from lower indices, then from st:
  - A = d[n]^d[n-2]^d[n-3]^d[n-5]^d[n-6]
  - B = d[n]^d[n-1]^d[n-2]^d[n-3]^d[n-6]
- Whole beat is computed combinationally (unrolled) and captured into a single output register.
- After an accepted beat, st takes the last 6 input bits: st[k] = tdata[WIDTH-1-k].
- After an accepted tlast beat, st clears to 0 instead.
- FSM has two states:
  - DATA: normal operation.
  - TAIL: exists only with the tail feature.
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, st=0, FSM=DATA.

## Timing
- Latency: input accepted at edge N appears on m_axis_* from edge N to N+1 (1 cycle).
- s_axis_tready = (~m_axis_tvalid | m_axis_tready) & (FSM==DATA).
  - Full throughput: one beat per cycle when downstream is always ready.
- Output register holds data and tlast stable while m_axis_tvalid=1 and m_axis_tready=0.
- Simultaneous output handshake and new input acceptance in one cycle: register reloads and m_axis_tvalid stays 1.
- Output handshake with no new input: m_axis_tvalid→0.
- m_axis_tlast mirrors the s_axis_tlast of the captured beat, unless retimed by the tail feature.
- Reset mid-frame discards the held output beat and the state; the next beat is encoded from st=0.
- Back-pressure never drops or duplicates beats.

## Configuration
- CONV_ENCODER_TAIL_EN defined:
  - Accepting a tlast beat loads that beat into the output register with m_axis_tlast=0 and enters TAIL.
  - In TAIL, s_axis_tready=0.
  - When the output register frees, it loads an encoding of WIDTH zero bits from the pre-clear state, with m_axis_tlast=1.
  - On that load: st←0 and FSM←DATA.
  - Frame output is one beat longer than frame input.
- CONV_ENCODER_TAIL_EN undefined:
  - No TAIL state; output beat count equals input beat count.
  - tlast passes through; st clears after the tlast beat.

## Test plan
- WIDTH=8, reset, input 0x00 (no tlast), tready=1 → output 0x0000 one cycle later; st stays 0.
- WIDTH=8 from st=0, input 0xFF with tlast, tail disabled → output 0xF167 with tlast=1; next beat 0x00 → 0x0000, confirming the state clear.
- Same stimulus with CONV_ENCODER_TAIL_EN → 0xF167 (tlast=0), then 0x0E98 (tlast=1); s_axis_tready=0 for the tail cycle.
- Frame 0xFF, 0xFF (tlast on second), no tail → first 0xF167; second uses st=all-ones and must match the golden model, not 0xF167.
- Random data over 1000 beats with random tvalid/tready → outputs match a bit-serial golden model; beat count preserved; no output change while stalled.
- Assert areset while m_axis_tvalid=1 mid-frame → next cycle m_axis_tvalid=0; next input 0xFF → 0xF167.
